// File: rtl/writeback_regfile.sv
// Writeback-stage register file: selects the writeback source, commits it to a
// zero-hardwired register file with write-through read bypass, and tracks halt state.
module writeback_regfile #(
    parameter int DATA_W = 32,
    parameter int NREG   = 32,
    parameter int AW     = (NREG > 1) ? $clog2(NREG) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] ReadData_WB,
    input  logic [DATA_W-1:0] ALU_Result_WB,
    input  logic [AW-1:0]     rd_WB,
    input  logic              reg_wr_WB,
    input  logic              sel4_WB,
    input  logic              hlt_WB,
    input  logic              clear_halt,
    input  logic [AW-1:0]     rs_addr,
    input  logic [AW-1:0]     rt_addr,
    output logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] rt_data,
    output logic [DATA_W-1:0] wb_data,
    output logic              halted,
    output logic [31:0]       wr_count,
    output logic [31:0]       run_cycles
);

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic              commit;
    logic [DATA_W-1:0] regs [NREG];
    logic [31:0]       wr_count_q;
    logic [31:0]       run_cycles_q;

    assign wb_data    = sel4_WB ? ReadData_WB : ALU_Result_WB;
    assign halted     = (state == HALTED);
    assign wr_count   = wr_count_q;
    assign run_cycles = run_cycles_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // A halt reaching writeback suppresses its own write; reset suppresses everything.
    always_comb begin
        state_nxt = state;
        commit    = 1'b0;
        case (state)
            RUN: begin
                if (hlt_WB) begin
                    state_nxt = HALTED;
                end
                commit = reg_wr_WB && !hlt_WB && (rd_WB != '0) && !reset;
            end
            HALTED: begin
                if (clear_halt) begin
                    state_nxt = RUN;
                end
            end
            default: state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (commit) begin
            regs[rd_WB] <= wb_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_count_q   <= '0;
            run_cycles_q <= '0;
        end else begin
            if (commit) begin
                wr_count_q <= wr_count_q + 32'd1;
            end
            if (state == RUN) begin
                run_cycles_q <= run_cycles_q + 32'd1;
            end
        end
    end

    // Register 0 reads zero even if the bypass would otherwise match.
    always_comb begin
        rs_data = '0;
        rt_data = '0;
        if (rs_addr != '0) begin
            rs_data = (commit && rd_WB == rs_addr) ? wb_data : regs[rs_addr];
        end
        if (rt_addr != '0) begin
            rt_data = (commit && rd_WB == rt_addr) ? wb_data : regs[rt_addr];
        end
    end

endmodule

// File: tb/tb_writeback_regfile.sv
// Bench for writeback_regfile: directed scenarios then random traffic, with expected
// outputs queued by the driver and compared by an independent monitor on the falling edge.
module tb_writeback_regfile;

    logic        clk;
    logic        reset;
    logic [31:0] ReadData_WB;
    logic [31:0] ALU_Result_WB;
    logic [4:0]  rd_WB;
    logic        reg_wr_WB;
    logic        sel4_WB;
    logic        hlt_WB;
    logic        clear_halt;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] wb_data;
    logic        halted;
    logic [31:0] wr_count;
    logic [31:0] run_cycles;

    writeback_regfile #(.DATA_W(32), .NREG(32)) dut (
        .clk(clk), .reset(reset),
        .ReadData_WB(ReadData_WB), .ALU_Result_WB(ALU_Result_WB),
        .rd_WB(rd_WB), .reg_wr_WB(reg_wr_WB), .sel4_WB(sel4_WB),
        .hlt_WB(hlt_WB), .clear_halt(clear_halt),
        .rs_addr(rs_addr), .rt_addr(rt_addr),
        .rs_data(rs_data), .rt_data(rt_data), .wb_data(wb_data),
        .halted(halted), .wr_count(wr_count), .run_cycles(run_cycles)
    );

    initial clk = 1'b1;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] wb;
        logic        h;
        logic [31:0] wc;
        logic [31:0] rc;
    } exp_t;

    exp_t        sb[$];
    int          passed = 0;
    int          total  = 0;

    // Architectural model: register contents, halt flag, counters
    logic [31:0] mregs [32];
    logic        mhalt;
    logic [31:0] mwc;
    logic [31:0] mrc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act === req) passed++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, req, $time);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("rs_data",    rs_data,          e.rs);
            check("rt_data",    rt_data,          e.rt);
            check("wb_data",    wb_data,          e.wb);
            check("halted",     {31'd0, halted},  {31'd0, e.h});
            check("wr_count",   wr_count,         e.wc);
            check("run_cycles", run_cycles,       e.rc);
        end
    end

    function automatic logic [31:0] model_read(input logic [4:0] a, input logic wr_now,
                                               input logic [4:0] rd, input logic [31:0] val);
        if (a == 5'd0) return 32'd0;
        if (wr_now && rd == a) return val;
        return mregs[a];
    endfunction

    task automatic step(input bit chk, input logic rst, input logic wr, input logic sel,
                        input logic hlt, input logic clr, input logic [4:0] rd,
                        input logic [4:0] rs, input logic [4:0] rt,
                        input logic [31:0] rdata, input logic [31:0] alu);
        exp_t        e;
        logic [31:0] val;
        logic        wr_now;
        reset = rst; reg_wr_WB = wr; sel4_WB = sel; hlt_WB = hlt; clear_halt = clr;
        rd_WB = rd; rs_addr = rs; rt_addr = rt; ReadData_WB = rdata; ALU_Result_WB = alu;
        val    = sel ? rdata : alu;
        wr_now = !rst && !mhalt && wr && !hlt && (rd != 5'd0);
        e.rs = model_read(rs, wr_now, rd, val);
        e.rt = model_read(rt, wr_now, rd, val);
        e.wb = val;
        e.h  = mhalt;
        e.wc = mwc;
        e.rc = mrc;
        if (chk) sb.push_back(e);
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
            mhalt = 1'b0;
            mwc   = 32'd0;
            mrc   = 32'd0;
        end else if (!mhalt) begin
            mrc = mrc + 32'd1;
            if (hlt) mhalt = 1'b1;
            else if (wr_now) begin
                mregs[rd] = val;
                mwc = mwc + 32'd1;
            end
        end else if (clr) begin
            mhalt = 1'b0;
        end
        #1;
    endtask

    task automatic idle(input logic [4:0] rs, input logic [4:0] rt);
        step(1, 0, 0, 0, 0, 0, 5'd0, rs, rt, 32'd0, 32'd0);
    endtask

    initial begin
        logic [4:0] rd, rs, rt;
        mhalt = 1'b0; mwc = 32'd0; mrc = 32'd0;
        for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
        // Bring-up reset: DUT state is unknown before it, so nothing is checked
        step(0, 1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0);
        step(1, 1, 1, 0, 0, 0, 5'd4, 5'd4, 5'd0, 32'd0, 32'h1111_1111);
        idle(5'd4, 5'd0);

        // Commit to r5, then read it back
        step(1, 0, 1, 0, 0, 0, 5'd5, 5'd5, 5'd0, 32'h0, 32'h0000_1234);
        idle(5'd5, 5'd5);
        // Bypass of a load result on rt
        step(1, 0, 1, 1, 0, 0, 5'd7, 5'd5, 5'd7, 32'hDEAD_BEEF, 32'h0BAD_0BAD);
        idle(5'd7, 5'd7);
        // Writes to r0 are dropped
        step(1, 0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 32'h0, 32'hFFFF_FFFF);
        idle(5'd0, 5'd0);
        // Halt with a write in flight, writes ignored while halted, then resume
        step(1, 0, 1, 0, 1, 0, 5'd3, 5'd3, 5'd3, 32'h0, 32'h5555_AAAA);
        idle(5'd3, 5'd0);
        step(1, 0, 1, 0, 0, 0, 5'd3, 5'd3, 5'd3, 32'h0, 32'h7777_7777);
        step(1, 0, 0, 0, 1, 0, 5'd0, 5'd3, 5'd0, 32'h0, 32'h0);
        idle(5'd3, 5'd5);
        step(1, 0, 0, 0, 0, 1, 5'd0, 5'd3, 5'd0, 32'h0, 32'h0);
        step(1, 0, 1, 0, 0, 1, 5'd3, 5'd3, 5'd0, 32'h0, 32'h3333_3333);
        idle(5'd3, 5'd0);

        // Commit counter wrap from all-ones
        #1 force dut.wr_count_q = 32'hFFFF_FFFF;
        #1 release dut.wr_count_q;
        mwc = 32'hFFFF_FFFF;
        idle(5'd0, 5'd0);
        step(1, 0, 1, 0, 0, 0, 5'd9, 5'd9, 5'd0, 32'h0, 32'h0000_0009);
        idle(5'd9, 5'd0);

        // Reset while halted, with resume and write requests in the same cycle
        step(1, 0, 0, 0, 1, 0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0);
        step(1, 1, 1, 0, 0, 1, 5'd9, 5'd9, 5'd5, 32'h0, 32'h9999_9999);
        idle(5'd9, 5'd5);
        idle(5'd7, 5'd3);

        // Random traffic with occasional halts, resumes and resets
        for (int n = 0; n < 3000; n++) begin
            rd = 5'($urandom_range(0, 31));
            rs = ($urandom_range(0, 2) == 0) ? rd : 5'($urandom_range(0, 31));
            rt = ($urandom_range(0, 2) == 0) ? rd : 5'($urandom_range(0, 31));
            step(1, ($urandom_range(0, 199) == 0), ($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 1)), ($urandom_range(0, 29) == 0),
                 ($urandom_range(0, 3) == 0), rd, rs, rt, $urandom, $urandom);
        end
        idle(5'd1, 5'd2);

        @(posedge clk);
        total++;
        if (sb.size() == 0) passed++;
        else $display("FAIL scoreboard_drain: got %0d entries left expected 0", sb.size());
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/writeback_regfile.md
WRITEBACK_REGFILE -- requirements
Module: writeback_regfile

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning the register and datapath width.
REQ-002 The block SHALL have parameter NREG, default 32, meaning the register count (address width 5).
REQ-003 The block SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 The block SHALL have port ReadData_WB  input  32  load data from the MEM/WB buffer.
REQ-006 The block SHALL have port ALU_Result_WB  input  32  ALU result from the MEM/WB buffer.
REQ-007 The block SHALL have port rd_WB  input  5  destination register index.
REQ-008 The block SHALL have port reg_wr_WB  input  1  register write request.
REQ-009 The block SHALL have port sel4_WB  input  1  writeback source select: 1 = ReadData_WB, 0 = ALU_Result_WB.
REQ-010 The block SHALL have port hlt_WB  input  1  a halt instruction has reached writeback.
REQ-011 The block SHALL have port clear_halt  input  1  resume request from the halted state.
REQ-012 The block SHALL have ports rs_addr and rt_addr  input  5 each  decode-stage read addresses.
REQ-013 The block SHALL have ports rs_data and rt_data  output  32 each  read data, combinational.
REQ-014 The block SHALL have port wb_data  output  32  selected writeback value, combinational.
REQ-015 The block SHALL have port halted  output  1  high while the FSM is in HALTED.
REQ-016 The block SHALL have port wr_count  output  32  number of committed register writes.
REQ-017 The block SHALL have port run_cycles  output  32  number of clock cycles spent in RUN.

Function
REQ-018 wb_data SHALL equal ReadData_WB when sel4_WB=1, else ALU_Result_WB, in every state.
REQ-019 The FSM SHALL have exactly two states: RUN (reset state) and HALTED.
REQ-020 In RUN, hlt_WB=1 SHALL move the FSM to HALTED at the next edge; clear_halt is ignored in RUN.
REQ-021 In HALTED, clear_halt=1 SHALL move the FSM to RUN at the next edge; hlt_WB is ignored in HALTED.
REQ-022 A commit SHALL occur on an edge when state=RUN, reg_wr_WB=1, hlt_WB=0 and rd_WB!=0; it writes wb_data to register rd_WB.
REQ-023 Writes to register 0 SHALL be discarded; register 0 SHALL always read 0.
REQ-024 In HALTED, and in the cycle where hlt_WB=1, no register write or wr_count increment SHALL occur.
REQ-025 A commit SHALL increment wr_count by 1, wrapping modulo 2^32 (0xFFFFFFFF -> 0).
REQ-026 run_cycles SHALL increment by 1 on every edge where state=RUN, including the edge that enters HALTED, wrapping modulo 2^32.
REQ-027 rs_data SHALL return register[rs_addr], except that when a commit is pending this cycle with rd_WB==rs_addr!=0, it SHALL return wb_data (write-through bypass); rt_data SHALL behave identically for rt_addr.
REQ-028 rs_addr or rt_addr = 0 SHALL return 0 regardless of the bypass.
REQ-029 halted SHALL be a registered decode of the state, with no combinational path from hlt_WB.

Reset
REQ-030 When reset=1 at an edge, all registers SHALL clear to 0, wr_count=0, run_cycles=0, and state=RUN (halted=0).
REQ-031 Reset SHALL take priority over commit, hlt_WB and clear_halt in the same cycle.
REQ-032 Asserting reset while in HALTED or mid-stream SHALL discard the pending write and leave no partial state.

Verification
REQ-033 Commit: reg_wr=1, rd=5, sel4=0, ALU=0x1234 -> next cycle rs_addr=5 reads 0x1234, wr_count=1.
REQ-034 Bypass: same cycle as a commit of rd=7 with ReadData=0xDEADBEEF and sel4=1, rt_addr=7 -> rt_data=0xDEADBEEF combinationally.
REQ-035 Zero register: reg_wr=1, rd=0, ALU=0xFFFFFFFF -> rs_addr=0 reads 0 and wr_count is unchanged.
REQ-036 Halt: hlt=1 with reg_wr=1 and rd=3 -> halted=1 next cycle, r3 is unchanged, run_cycles freezes, and later writes are ignored; clear_halt=1 -> RUN, and counting resumes.
REQ-037 Wrap: preload wr_count to 0xFFFFFFFF via 2^32-1 commits (or force) -> one more commit yields 0.
REQ-038 Reset mid-halt: reset=1 with clear_halt=1 and reg_wr=1 -> all outputs 0, state=RUN, and no write occurs.
